// File: rtl/serial_word_loader_if.sv
// Serial-bit in / parallel-word out bundle for serial_word_loader.
// master = bit source and word sink side, slave = the loader itself.
interface serial_word_loader_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic              ser_valid;
    logic              ser_data;
    logic              ser_ready;
    logic              ser_abort;
    logic [WIDTH-1:0]  word_out;
    logic [ADDR_W-1:0] word_addr;
    logic              word_valid;
    logic              word_ready;
    logic [CNT_W-1:0]  bit_count;

    modport master (
        output ser_valid, ser_data, ser_abort, word_ready,
        input  ser_ready, word_out, word_addr, word_valid, bit_count
    );

    modport slave (
        input  ser_valid, ser_data, ser_abort, word_ready,
        output ser_ready, word_out, word_addr, word_valid, bit_count
    );
endinterface

// File: rtl/serial_word_loader.sv
// Assembles LSB-first serial bits into WIDTH-bit words with a sequential address.
// word_valid registered on the last-bit edge (0 cycles); source stalled via ser_ready=0 while a word is held.
module serial_word_loader #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_loader_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  part_q, part_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  bit_sel;
    logic [WIDTH-1:0]  part_with_bit;

    // Positions at or above cnt_q are always zero, so OR-ing in the new bit is enough.
    assign bit_sel       = WIDTH'(1) << cnt_q;
    assign part_with_bit = bus.ser_data ? (part_q | bit_sel) : part_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        word_d  = word_q;
        addr_d  = addr_q;
        unique case (state_q)
            COLLECT: begin
                if (bus.ser_abort) begin
                    cnt_d  = '0;
                    part_d = '0;
                end else if (bus.ser_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        word_d  = part_with_bit;
                        part_d  = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        part_d = part_with_bit;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    state_d = COLLECT;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            part_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    // Handshake outputs decode straight from state so reset reaches them without a clock.
    assign bus.ser_ready  = (state_q == COLLECT);
    assign bus.word_valid = (state_q == HOLD);
    assign bus.word_out   = word_q;
    assign bus.word_addr  = addr_q;
    assign bus.bit_count  = cnt_q;
endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: directed cases then 1000 random-gap words.
// Narrow address counter so wrap-around is reached within the random run.
module tb_serial_word_loader;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [WIDTH-1:0]  w;
        logic [ADDR_W-1:0] a;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_word_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    serial_word_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int timeouts  = 0;
    int pushed    = 0;
    int hs_cnt    = 0;
    int ready_pct = 100;
    bit end_req   = 1'b0;
    bit end_done  = 1'b0;

    exp_t              sb_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;

    // Reference model state
    bit                m_hold = 1'b0;
    logic [4:0]        m_cnt  = '0;
    logic [WIDTH-1:0]  m_part = '0;
    logic [WIDTH-1:0]  m_word = '0;
    logic [ADDR_W-1:0] m_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checker / model: all comparisons happen here, on negedge clk or right after reset falls.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            check("rst_ready", 32'(bus.ser_ready), 32'd1);
            check("rst_valid", 32'(bus.word_valid), 32'd0);
            check("rst_cnt", 32'(bus.bit_count), 32'd0);
            check("rst_word", 32'(bus.word_out), 32'd0);
            check("rst_addr", 32'(bus.word_addr), 32'd0);
            m_hold = 1'b0;
            m_cnt  = '0;
            m_part = '0;
            m_word = '0;
            m_addr = '0;
        end else begin
            check("ready", 32'(bus.ser_ready), 32'(!m_hold));
            check("valid", 32'(bus.word_valid), 32'(m_hold));
            check("cnt", 32'(bus.bit_count), 32'(m_cnt));
            check("word_stable", 32'(bus.word_out), 32'(m_word));
            check("addr", 32'(bus.word_addr), 32'(m_addr));
            if (m_hold && bus.word_ready) begin
                check("sb_avail", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("hs_word", 32'(bus.word_out), 32'(e.w));
                    check("hs_addr", 32'(bus.word_addr), 32'(e.a));
                end
                hs_cnt++;
                m_hold = 1'b0;
                m_addr = m_addr + 1'b1;
            end else if (!m_hold) begin
                if (bus.ser_abort) begin
                    m_cnt  = '0;
                    m_part = '0;
                end else if (bus.ser_valid) begin
                    m_part[m_cnt] = bus.ser_data;
                    if (m_cnt == 5'(WIDTH - 1)) begin
                        m_word = m_part;
                        m_part = '0;
                        m_cnt  = '0;
                        m_hold = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 1'b1;
                    end
                end
            end
            if (end_req && !end_done) begin
                check("sb_empty", 32'(sb_q.size()), 32'd0);
                check("timeouts", 32'(timeouts), 32'd0);
                check("hs_count", 32'(hs_cnt), 32'(pushed));
                end_done = 1'b1;
            end
        end
    end

    // Word sink with a tunable acceptance rate.
    initial begin
        bus.word_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.word_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Present bits LSB first, holding each until accepted; called and returns at posedge+1.
    task automatic send_bits(input logic [WIDTH-1:0] w, input int n, input int vpct);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int guard;
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                bus.ser_data  = w[i];
                bus.ser_valid = ($urandom_range(99) < vpct);
                @(negedge clk);
                acc = bus.ser_valid && bus.ser_ready;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 2000) begin
                    timeouts++;
                    acc = 1'b1;
                end
            end
        end
        bus.ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int vpct);
        exp_t e;
        e.w = w;
        e.a = exp_addr;
        sb_q.push_back(e);
        pushed++;
        exp_addr = exp_addr + 1'b1;
        send_bits(w, WIDTH, vpct);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_addr = '0;
    endtask

    initial begin
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        bus.ser_abort = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back word with sink always ready
        send_word(16'hA5C3, 100);

        // Sink stalls 5 cycles while the source keeps pushing the next word
        repeat (3) @(posedge clk);
        #1;
        ready_pct = 0;
        send_word(16'hA5C3, 100);
        fork
            begin
                repeat (5) @(posedge clk);
                ready_pct = 100;
            end
            send_word(16'h3C5A, 100);
        join

        // Async reset mid-word, then all-ones word from address 0
        send_bits(16'hFFFF, 9, 100);
        pulse_reset();
        send_word(16'hFFFF, 100);

        // Abort coinciding with the 8th bit
        pulse_reset();
        send_bits(16'h5A5A, 7, 100);
        bus.ser_valid = 1'b1;
        bus.ser_data  = 1'b1;
        bus.ser_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.ser_abort = 1'b0;
        bus.ser_valid = 1'b0;
        send_word(16'h0001, 100);

        // Random gaps on both sides; address wraps several times
        ready_pct = 60;
        for (int k = 0; k < 1000; k++) begin
            send_word(16'($urandom()), 70);
        end

        ready_pct = 100;
        repeat (6) @(posedge clk);
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
